column_shift_receiver: RTL and testbench

Receiving end of the LED-matrix column serial link: oversamples `ser_data`, `ser_clk`, `latch` and `row_en` in the local clock domain and shifts in one row of RGB column data. On `latch` it presents the row as parallel `col_r`/`col_g`/`col_b` tagged with the row select. It sits opposite the column driver and is used both as the on-board receiver model and as the bus monitor in matrix-level benches. It also detects malformed frames (wrong bit count at latch) and counts them.

---
 rtl/column_shift_receiver.sv | 128 ++++++++++++
 tb/tb_column_shift_receiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/column_shift_receiver.sv
// Receiver for the LED-matrix column serial link: oversamples the link inputs,
// shifts in one RGB row and presents it on latch, flagging frames of the wrong length.
module column_shift_receiver #(
    parameter int COL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_data,
    input  logic             ser_clk,
    input  logic             latch,
    input  logic [2:0]       row_en,
    output logic [COL_W-1:0] col_r,
    output logic [COL_W-1:0] col_g,
    output logic [COL_W-1:0] col_b,
    output logic [2:0]       row_out,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    localparam int FRAME = 3 * COL_W;
    localparam int CW    = $clog2(FRAME + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

    state_t state, state_shift, state_next;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic latch_s1, latch_s2, latch_s3;
    logic data_s1, data_s2;
    logic [2:0] row_s1, row_s2;

    logic [FRAME-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_shift, cnt_next;
    logic             sclk_rise, latch_rise, good, bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            latch_s1 <= 1'b0;
            latch_s2 <= 1'b0;
            latch_s3 <= 1'b0;
            data_s1  <= 1'b0;
            data_s2  <= 1'b0;
            row_s1   <= '0;
            row_s2   <= '0;
        end else begin
            sclk_s1  <= ser_clk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            latch_s1 <= latch;
            latch_s2 <= latch_s1;
            latch_s3 <= latch_s2;
            data_s1  <= ser_data;
            data_s2  <= data_s1;
            row_s1   <= row_en;
            row_s2   <= row_s1;
        end
    end

    assign sclk_rise  = sclk_s2 & ~sclk_s3;
    assign latch_rise = latch_s2 & ~latch_s3;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The incoming bit is applied first so a coincident latch judges the updated count.
    always_comb begin
        shreg_next  = shreg;
        cnt_shift   = cnt;
        state_shift = state;
        if (sclk_rise) begin
            shreg_next = {shreg[FRAME-2:0], data_s2};
            if (cnt != CNT_MAX) cnt_shift = cnt + 1'b1;
            case (state)
                IDLE, SHIFT: state_shift = (cnt_shift == CNT_FULL) ? FULL : SHIFT;
                FULL:        state_shift = OVER;
                default:     state_shift = OVER;
            endcase
        end
        state_next = state_shift;
        cnt_next   = cnt_shift;
        good       = 1'b0;
        bad        = 1'b0;
        if (latch_rise) begin
            state_next = IDLE;
            cnt_next   = '0;
            good       = (state_shift == FULL);
            bad        = (state_shift != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            cnt         <= '0;
            col_r       <= '0;
            col_g       <= '0;
            col_b       <= '0;
            row_out     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            shreg       <= shreg_next;
            cnt         <= cnt_next;
            frame_valid <= good;
            frame_err   <= bad;
            if (good) begin
                col_r   <= shreg_next[FRAME-1 -: COL_W];
                col_g   <= shreg_next[2*COL_W-1 -: COL_W];
                col_b   <= shreg_next[COL_W-1:0];
                row_out <= row_s2;
            end
            if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_column_shift_receiver.sv
// Scoreboard bench for column_shift_receiver: a bit-queue model predicts each latch
// outcome and an independent monitor checks every frame_valid/frame_err pulse.
module tb_column_shift_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_data = 1'b0;
    logic       ser_clk = 1'b0;
    logic       latch = 1'b0;
    logic [2:0] row_en = 3'd0;
    logic [7:0] col_r, col_g, col_b;
    logic [2:0] row_out;
    logic       frame_valid, frame_err, busy;
    logic [7:0] err_cnt;

    column_shift_receiver #(.COL_W(8)) dut (
        .clk(clk), .rst(rst), .ser_data(ser_data), .ser_clk(ser_clk),
        .latch(latch), .row_en(row_en), .col_r(col_r), .col_g(col_g),
        .col_b(col_b), .row_out(row_out), .frame_valid(frame_valid),
        .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       good;
        logic [7:0] r, g, b;
        logic [2:0] row;
        logic [7:0] errs;
    } exp_t;

    exp_t sb[$];
    logic bits[$];
    logic [7:0] m_r = 8'd0, m_g = 8'd0, m_b = 8'd0;
    logic [2:0] m_row = 3'd0;
    int m_errs = 0;
    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a frame is good exactly when 24 bits arrived since the last latch/reset.
    function automatic void model_latch(input logic [2:0] row);
        exp_t e;
        logic [23:0] v;
        v = 24'd0;
        if (bits.size() == 24) begin
            for (int i = 0; i < 24; i++) v = {v[22:0], bits[i]};
            m_r = v[23:16];
            m_g = v[15:8];
            m_b = v[7:0];
            m_row = row;
            e.good = 1'b1;
        end else begin
            if (m_errs < 255) m_errs++;
            e.good = 1'b0;
        end
        e.r = m_r; e.g = m_g; e.b = m_b; e.row = m_row; e.errs = 8'(m_errs);
        sb.push_back(e);
        bits.delete();
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        ser_data = b;
        bits.push_back(b);
        repeat (2) @(negedge clk);
        ser_clk = 1'b1;
        repeat (2) @(negedge clk);
        ser_clk = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[23 - (i % 24)]);
    endtask

    // Raise latch (optionally together with a final ser_clk rise) and check 3-cycle latency.
    task automatic do_latch(input logic [2:0] row, input logic with_bit, input logic b);
        int found;
        @(negedge clk);
        row_en = row;
        if (with_bit) begin
            ser_data = b;
            bits.push_back(b);
        end
        model_latch(row);
        repeat (2) @(negedge clk);
        latch = 1'b1;
        if (with_bit) ser_clk = 1'b1;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (found == 0 && (frame_valid || frame_err)) found = k;
        end
        checkOutput("latch_latency", found, 3);
        @(negedge clk);
        latch = 1'b0;
        ser_clk = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("busy_after_latch", busy, 1'b0);
    endtask

    task automatic applyStimulus(input logic [23:0] w, input int n, input logic [2:0] row);
        send_word(w, n);
        if (n > 0) checkOutput("busy_after_bits", busy, 1'b1);
        do_latch(row, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bits.delete();
        m_errs = 0;
        m_r = 8'd0; m_g = 8'd0; m_b = 8'd0; m_row = 3'd0;
    endtask

    // Monitor: every output pulse must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (frame_valid || frame_err)) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", {frame_valid, frame_err}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    checkOutput("frame_valid", frame_valid, e.good);
                    checkOutput("frame_err", frame_err, !e.good);
                    checkOutput("col_r", col_r, e.r);
                    checkOutput("col_g", col_g, e.g);
                    checkOutput("col_b", col_b, e.b);
                    checkOutput("row_out", row_out, e.row);
                    checkOutput("err_cnt", err_cnt, e.errs);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [23:0] w;
        int kind, n;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_cols", {col_r, col_g, col_b}, 24'd0);
        checkOutput("reset_row", row_out, 3'd0);
        checkOutput("reset_pulses", {frame_valid, frame_err}, 2'b00);
        checkOutput("reset_err_cnt", err_cnt, 8'd0);
        checkOutput("reset_busy", busy, 1'b0);

        $display("[TB] good frame");
        applyStimulus(24'hA53CF0, 24, 3'd5);
        $display("[TB] short frame");
        applyStimulus(24'h123456, 23, 3'd2);
        $display("[TB] long frame then good");
        applyStimulus(24'hFFFFFF, 26, 3'd6);
        applyStimulus(24'h010203, 24, 3'd1);

        $display("[TB] coincident edge");
        send_word(24'hC3_5A_96, 23);
        do_latch(3'd3, 1'b1, 1'b0);

        $display("[TB] reset mid-frame");
        send_word(24'hABCDEF, 12);
        pulse_reset();
        checkOutput("busy_after_reset", busy, 1'b0);
        applyStimulus(24'h7E_81_42, 24, 3'd7);
        checkOutput("err_after_reset", err_cnt, 8'd0);
        applyStimulus(24'd0, 0, 3'd0);

        $display("[TB] random frames");
        for (int f = 0; f < 10; f++) begin
            w = 24'($urandom);
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1: n = 24;
                2:    n = $urandom_range(1, 23);
                default: n = $urandom_range(25, 29);
            endcase
            applyStimulus(w, n, 3'($urandom));
        end

        $display("[TB] saturation");
        for (int i = 0; i < 260; i++) do_latch(3'($urandom), 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("err_cnt_saturated", err_cnt, 8'd255);

        repeat (10) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
